// File: rtl/m_ext_pkg.sv
// Shared M-extension types: divide opcodes (also used by decode), divider FSM
// states and the iteration count.
package m_ext_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned DIV_ITERS = XLEN;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } div_state_e;

endpackage

// File: rtl/div_sign_fix.sv
// Final result shaping for the iterative divider: applies the sign of the
// quotient/remainder, forces the divide-by-zero quotient and selects which
// of the two the opcode asked for.
module div_sign_fix #(
  parameter int unsigned XLEN = 32
) (
  input  logic            is_rem,
  input  logic            q_neg,
  input  logic            r_neg,
  input  logic            div0,
  input  logic [XLEN-1:0] quot,
  input  logic [XLEN-1:0] rem,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] quot_signed;
  logic [XLEN-1:0] rem_signed;

  // Magnitudes in, two's-complement out; divide-by-zero quotient is all ones
  // irrespective of operand signs.
  always_comb begin
    quot_signed = q_neg ? (~quot + 1'b1) : quot;
    rem_signed  = r_neg ? (~rem + 1'b1) : rem;
    if (is_rem) begin
      result = rem_signed;
    end else if (div0) begin
      result = '1;
    end else begin
      result = quot_signed;
    end
  end

endmodule

// File: rtl/divider_iterative.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per
// clock. Optional macro DIV_EARLY_OUT_EN skips the iterations when
// |dividend| < |divisor|.
module divider_iterative
  import m_ext_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            startE,
  input  logic [1:0]      div_opcode,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  output logic [XLEN-1:0] result_divide,
  output logic            ready,
  output logic            busy
);

  localparam int unsigned CntW = $clog2(XLEN);

  div_state_e      state;
  div_op_e         op_q;
  logic [XLEN-1:0] dvd_q;    // dividend bits shift out, quotient bits shift in
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] dsr_q;
  logic [CntW-1:0] count_q;
  logic            q_neg_q;
  logic            r_neg_q;
  logic            div0_q;
  logic            skip_q;   // result preloaded, no iterations needed

  // Start-edge operand decode.
  div_op_e         op_in;
  logic            is_signed;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            div0;
  logic            ovf;
  logic            early;
  logic            skip;

  // Decode opcode, operand signs/magnitudes and the special cases.
  always_comb begin
    op_in     = div_op_e'(div_opcode);
    is_signed = (op_in == DIV) || (op_in == REM);
    a_neg     = is_signed & operand1[XLEN-1];
    b_neg     = is_signed & operand2[XLEN-1];
    a_mag     = a_neg ? (~operand1 + 1'b1) : operand1;
    b_mag     = b_neg ? (~operand2 + 1'b1) : operand2;
    div0      = (operand2 == '0);
    ovf       = is_signed && (operand1 == {1'b1, {(XLEN-1){1'b0}}}) && (operand2 == '1);
`ifdef DIV_EARLY_OUT_EN
    early     = (a_mag < b_mag);
`else
    early     = 1'b0;
`endif
    skip      = div0 | ovf | early;
  end

  // One restoring step: shift in next dividend bit, trial-subtract divisor.
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic            ge;
  logic [XLEN-1:0] rem_nx;
  logic [XLEN-1:0] quot_nx;
  logic [XLEN-1:0] fin_quot;
  logic [XLEN-1:0] fin_rem;
  logic [XLEN-1:0] fixed;

  // Iteration datapath and selection of the value to be loaded at DONE.
  always_comb begin
    shifted  = {rem_q, dvd_q[XLEN-1]};
    diff     = shifted - {1'b0, dsr_q};
    ge       = ~diff[XLEN];
    rem_nx   = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    quot_nx  = {dvd_q[XLEN-2:0], ge};
    fin_quot = skip_q ? dvd_q : quot_nx;
    fin_rem  = skip_q ? rem_q : rem_nx;
  end

  div_sign_fix #(
    .XLEN (XLEN)
  ) u_sign_fix (
    .is_rem (op_q == REM || op_q == REMU),
    .q_neg  (q_neg_q),
    .r_neg  (r_neg_q),
    .div0   (div0_q),
    .quot   (fin_quot),
    .rem    (fin_rem),
    .result (fixed)
  );

  // Control FSM and datapath registers. Special cases preload the magnitudes
  // and spend a single CALC cycle so ready lands in the cycle after edge 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      op_q          <= DIV;
      dvd_q         <= '0;
      rem_q         <= '0;
      dsr_q         <= '0;
      count_q       <= '0;
      q_neg_q       <= 1'b0;
      r_neg_q       <= 1'b0;
      div0_q        <= 1'b0;
      skip_q        <= 1'b0;
      result_divide <= '0;
      ready         <= 1'b0;
      busy          <= 1'b0;
    end else begin
      ready <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (startE) begin
            op_q    <= op_in;
            dsr_q   <= b_mag;
            q_neg_q <= a_neg ^ b_neg;
            r_neg_q <= a_neg;
            div0_q  <= div0;
            skip_q  <= skip;
            count_q <= '0;
            // Overflow: quotient magnitude equals |dividend|, remainder 0.
            // Div-by-zero / early-out: remainder is |dividend|.
            dvd_q   <= (skip && !ovf) ? '0 : a_mag;
            rem_q   <= (skip && !ovf) ? a_mag : '0;
            state   <= CALC;
            busy    <= 1'b1;
          end else begin
            state   <= IDLE;
          end
        end
        CALC: begin
          if (!skip_q) begin
            dvd_q   <= quot_nx;
            rem_q   <= rem_nx;
            count_q <= count_q + CntW'(1);
          end
          if (skip_q || count_q == CntW'(XLEN - 1)) begin
            result_divide <= fixed;
            ready         <= 1'b1;
            busy          <= 1'b0;
            state         <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_iterative.sv
module tb_divider_iterative;
  import m_ext_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        startE;
  logic [1:0]  div_opcode;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic [31:0] result_divide;
  logic        ready;
  logic        busy;

  int tests = 0;
  int fails = 0;

`ifdef DIV_EARLY_OUT_EN
  localparam int EarlyLat = 1;
`else
  localparam int EarlyLat = 32;
`endif

  always #5 clk = ~clk;

  divider_iterative #(
    .XLEN (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .startE        (startE),
    .div_opcode    (div_opcode),
    .operand1      (operand1),
    .operand2      (operand2),
    .result_divide (result_divide),
    .ready         (ready),
    .busy          (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Launch one operation, scramble operands after the start edge, wait for
  // ready, then check latency, result and that ready drops again.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input int exp_lat, input int exp_busy);
    int lat;
    int busy_cnt;
    @(negedge clk);
    div_opcode = op;
    operand1   = a;
    operand2   = b;
    startE     = 1'b1;
    @(posedge clk);
    #1;
    startE   = 1'b0;
    operand1 = $urandom;
    operand2 = $urandom;
    busy_cnt = int'(busy);
    lat      = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (ready) begin
        lat = n;
        break;
      end
      busy_cnt += int'(busy);
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_res"}, result_divide, exp_res);
    if (exp_busy >= 0) check({tag, "_busy"}, 32'(busy_cnt), 32'(exp_busy));
    @(posedge clk);
    #1;
    check({tag, "_rdy_drop"}, 32'(ready), 32'd0);
  endtask

  initial begin
    int lat;
    int rdy_cnt;
    rst        = 1'b0;
    startE     = 1'b0;
    div_opcode = 2'b00;
    operand1   = '0;
    operand2   = '0;
    #12;
    check("rst_result", result_divide, 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Normal path
    run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 32, 32);
    run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 32, -1);
    run_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32, -1);
    run_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32, -1);
    run_op("div_7_m2", 2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32, -1);
    run_op("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32, -1);
    run_op("divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32, -1);
    run_op("div_min_2", 2'b00, 32'h8000_0000, 32'd2, 32'hC000_0000, 32, -1);

    // Special cases
    run_op("div_5_0", 2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, -1);
    run_op("remu_5_0", 2'b11, 32'd5, 32'd0, 32'd5, 1, -1);
    run_op("rem_m7_0", 2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1, -1);
    run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, -1);
    run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, -1);

    // |dividend| < |divisor|: early-out candidates
    run_op("divu_3_10", 2'b01, 32'd3, 32'd10, 32'd0, EarlyLat, -1);
    run_op("remu_3_10", 2'b11, 32'd3, 32'd10, 32'd3, EarlyLat, -1);
    run_op("divu_min_m1", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, EarlyLat, -1);
    run_op("rem_m3_10", 2'b10, 32'hFFFF_FFFD, 32'd10, 32'hFFFF_FFFD, EarlyLat, -1);

    // startE while busy is ignored
    @(negedge clk);
    div_opcode = 2'b01;
    operand1   = 32'd1000;
    operand2   = 32'd3;
    startE     = 1'b1;
    @(posedge clk);
    #1;
    startE = 1'b0;
    lat    = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (n == 10) begin
        startE     = 1'b1;
        div_opcode = 2'b11;
        operand1   = 32'd5;
        operand2   = 32'd1;
      end else begin
        startE = 1'b0;
      end
      if (ready) begin
        lat = n;
        break;
      end
    end
    check("ign_lat", 32'(lat), 32'd32);
    check("ign_res", result_divide, 32'd333);
    @(posedge clk);
    #1;
    check("ign_rdy_drop", 32'(ready), 32'd0);

    // Asynchronous reset in the middle of CALC
    @(negedge clk);
    div_opcode = 2'b01;
    operand1   = 32'd100;
    operand2   = 32'd7;
    startE     = 1'b1;
    @(posedge clk);
    #1;
    startE = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("abort_ready", 32'(ready), 32'd0);
    check("abort_result", result_divide, 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_state", 32'(dut.state), 32'(IDLE));
    @(negedge clk);
    rst     = 1'b1;
    rdy_cnt = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      rdy_cnt += int'(ready);
    end
    check("abort_no_ready", 32'(rdy_cnt), 32'd0);

    // Unit still usable after the abort
    run_op("post_abort", 2'b01, 32'd100, 32'd7, 32'd14, 32, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/divider_iterative.md
Name: divider_iterative

Overview:
- Sequential radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU group.
- Sits directly downstream of the M-extension decode stage, which drives operand1, operand2 and div_opcode and waits on ready.
- Replaces the single-cycle combinational divider on the EX path with a 32-iteration unit.
- Uses a start/ready handshake matching the iterative multiplier.

Parameters:
- XLEN, 32: operand/result width; also the iteration count.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- startE  input  1  start request, sampled on clk
- div_opcode  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- operand1  input  XLEN  dividend
- operand2  input  XLEN  divisor
- result_divide  output  XLEN  registered quotient or remainder
- ready  output  1  one-cycle result-valid pulse
- busy  output  1  high while in CALC

Behaviour:
- Reset (rst=0, async): state=IDLE, result_divide=0, ready=0, busy=0, all internal registers 0. Reset mid-CALC aborts the operation with no ready pulse.
- States and transitions:
  - IDLE: on startE=1, latch the opcode, operand signs and operand magnitudes. Go to DONE on a special case, else to CALC with iteration count 0.
  - CALC: one quotient bit per edge. Shift the remainder left, bring in the next dividend MSB, trial-subtract the divisor magnitude; if non-negative, keep the difference and set the quotient bit to 1. After XLEN iterations go to DONE, loading result_divide and setting ready=1 on that edge.
  - DONE: ready=1 for exactly this one cycle. Next edge returns to IDLE, or starts a new operation if startE=1.
- startE is ignored while busy. Operands only need to be valid on the start edge.
- Latency:
  - Normal: ready is high in the cycle after edge XLEN, where edge 0 is the start-sample edge.
  - Special case: ready is high in the cycle after edge 1.
- result_divide holds its value until the next result load. ready is never asserted outside DONE.
- Signed ops (DIV, REM): divide the magnitudes. Negate the quotient iff the operand signs differ; the remainder takes the dividend's sign. Unsigned ops use raw values.
- Special cases (RISC-V spec):
  - Divisor 0: quotient = all ones, remainder = dividend.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- Magnitude of 0x80000000 is 0x80000000 in unsigned XLEN arithmetic; the narrowest magnitude width that handles it correctly is XLEN bits.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- When defined: in IDLE, if |dividend| < |divisor| (unsigned compare of magnitudes) and no special case applies, go straight to DONE with quotient 0 and remainder = dividend. Latency is then 1.
- When undefined: that case runs the full XLEN iterations. Results are identical either way; only latency differs.

Decomposition:
- Shared package m_ext_pkg holds:
  - enum div_op_e (DIV, DIVU, REM, REMU), also used by the decode stage;
  - enum div_state_e (IDLE, CALC, DONE);
  - constant DIV_ITERS = XLEN.
- One natural sub-module, div_sign_fix: combinational final negation and selection of quotient vs remainder, plus special-case muxing.

Test Plan:
- DIVU 100 / 7 -> ready after 32 edges, result_divide=14. REMU of the same operands -> 2. busy is high for 32 cycles.
- DIV -7 / 2 -> 0xFFFFFFFD (-3). REM -7 / 2 -> 0xFFFFFFFF (-1). DIV 7 / -2 -> -3.
- DIV 5 / 0 -> 0xFFFFFFFF. REMU 5 / 0 -> 5. Both give ready in the cycle after edge 1.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0. Both take the 1-cycle path.
- startE pulsed again at iteration 10 with different operands -> ignored, original result returned. Then rst=0 mid-CALC -> ready=0, result_divide=0, state=IDLE.
- With DIV_EARLY_OUT_EN defined: DIVU 3 / 10 -> ready after 1 edge, result 0. REMU 3 / 10 -> 3. Same results after 32 edges when the macro is undefined.
